cabac_mv_pair_serializer: RTL and testbench

- Sits directly downstream of the inter-MV binarizer and consumes its 30 context pairs: 15 for list 0 and 15 for list 1.
- Latches one CU/PU's pairs on a start pulse, drops empty pairs, and streams the remaining pairs one per cycle to the CABAC bin arithmetic encoder.
- Uses a valid/ready handshake and signals completion with a done pulse.

---
 rtl/cabac_mv_pair_serializer.sv | 152 +++++++++++++++
 tb/tb_cabac_mv_pair_serializer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/cabac_mv_pair_serializer.sv
// cabac_mv_pair_serializer
//   Latches the 30 context pairs produced by the inter-MV binarizer for one
//   CU/PU (15 for list 0 followed by 15 for list 1). Pairs of an unused list
//   and pairs with mode 00 are dropped. The remaining pairs are streamed in
//   ascending index order, one per cycle, to the CABAC bin encoder over a
//   valid/ready handshake. A one-cycle done pulse closes each start.
//
//   Ports
//     clk, rst_n    clock, asynchronous active-low reset
//     start_i       latch request, honoured only while idle_o=1
//     dir_mask_i    [0] list0 used, [1] list1 used
//     ctx_pairs_i   pair k at [PAIR_W*k +: PAIR_W], k=0..2*PAIR_NUM-1
//     pair_o        current pair toward the encoder (registered)
//     pair_valid_o  pair_o is valid (registered)
//     pair_ready_i  encoder accepts pair_o this cycle
//     done_o        one-cycle pulse after the last accept / empty start
//     pair_cnt_o    pairs accepted for the current start, held until next start
//     idle_o        block can accept start_i
//
//   Pair format: [PAIR_W-1:PAIR_W-2] mode (00 empty, 01 regular, 10 bypass,
//   11 terminate), [PAIR_W-3] bin value, remaining bits context index.

module cabac_mv_pair_serializer #(
  parameter int unsigned PAIR_W   = 11,
  parameter int unsigned PAIR_NUM = 15
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start_i,
  input  logic [1:0]                   dir_mask_i,
  input  logic [2*PAIR_NUM*PAIR_W-1:0] ctx_pairs_i,
  output logic [PAIR_W-1:0]            pair_o,
  output logic                         pair_valid_o,
  input  logic                         pair_ready_i,
  output logic                         done_o,
  output logic [4:0]                   pair_cnt_o,
  output logic                         idle_o
);

  localparam int unsigned TOT   = 2 * PAIR_NUM;
  localparam int unsigned IDX_W = $clog2(TOT);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    FIN
  } state_t;

  state_t                     state_q;
  logic [TOT*PAIR_W-1:0]      pairs_q;
  logic [TOT-1:0]             mask_q;
  logic [IDX_W-1:0]           cur_idx_q;

  logic [TOT-1:0]             in_pend;
  logic [TOT-1:0]             mask_clr;
  logic [TOT-1:0]             sel_mask;
  logic                       use_in;
  logic                       nxt_any;
  logic [IDX_W-1:0]           nxt_idx;
  logic [PAIR_W-1:0]          nxt_pair;

  // The next pair to present is looked up one edge ahead: from the live
  // inputs when a start is being taken, otherwise from the latched pairs with
  // the entry currently on the bus already removed. This gives a registered
  // pair_o with no skip cycles between beats.
  always_comb begin
    in_pend = '0;
    for (int unsigned k = 0; k < TOT; k++) begin
      in_pend[k] = (ctx_pairs_i[k*PAIR_W + PAIR_W - 2 +: 2] != 2'b00) &&
                   ((k < PAIR_NUM) ? dir_mask_i[0] : dir_mask_i[1]);
    end

    mask_clr            = mask_q;
    mask_clr[cur_idx_q] = 1'b0;

    use_in   = (state_q != SEND);
    sel_mask = use_in ? in_pend : mask_clr;
    nxt_any  = |sel_mask;

    nxt_idx = '0;
    for (int unsigned k = TOT; k > 0; k--) begin
      if (sel_mask[k-1]) nxt_idx = IDX_W'(k - 1);
    end

    nxt_pair = use_in ? ctx_pairs_i[nxt_idx*PAIR_W +: PAIR_W]
                      : pairs_q[nxt_idx*PAIR_W +: PAIR_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pairs_q      <= '0;
      mask_q       <= '0;
      cur_idx_q    <= '0;
      pair_o       <= '0;
      pair_valid_o <= 1'b0;
      done_o       <= 1'b0;
      pair_cnt_o   <= '0;
      idle_o       <= 1'b1;
    end else begin
      case (state_q)
        // FIN shares IDLE's start handling so a start in the done cycle is
        // taken without losing a cycle.
        IDLE, FIN: begin
          done_o  <= 1'b0;
          idle_o  <= 1'b1;
          state_q <= IDLE;
          if (start_i) begin
            pairs_q    <= ctx_pairs_i;
            mask_q     <= in_pend;
            pair_cnt_o <= '0;
            if (nxt_any) begin
              state_q      <= SEND;
              pair_o       <= nxt_pair;
              pair_valid_o <= 1'b1;
              cur_idx_q    <= nxt_idx;
              idle_o       <= 1'b0;
            end else begin
              state_q <= FIN;
              done_o  <= 1'b1;
            end
          end
        end

        SEND: begin
          if (pair_ready_i) begin
            mask_q     <= mask_clr;
            pair_cnt_o <= pair_cnt_o + 5'd1;
            if (nxt_any) begin
              pair_o    <= nxt_pair;
              cur_idx_q <= nxt_idx;
            end else begin
              pair_o       <= '0;
              pair_valid_o <= 1'b0;
              done_o       <= 1'b1;
              idle_o       <= 1'b1;
              state_q      <= FIN;
            end
          end
        end

        default: begin
          state_q      <= IDLE;
          pair_valid_o <= 1'b0;
          done_o       <= 1'b0;
          idle_o       <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cabac_mv_pair_serializer.sv
module tb_cabac_mv_pair_serializer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_i = 1'b0;
  logic [1:0]   dir_mask_i = '0;
  logic [329:0] ctx_pairs_i = '0;
  logic [10:0]  pair_o;
  logic         pair_valid_o;
  logic         pair_ready_i = 1'b0;
  logic         done_o;
  logic [4:0]   pair_cnt_o;
  logic         idle_o;

  int pass_cnt = 0;
  int total    = 0;

  cabac_mv_pair_serializer #(.PAIR_W(11), .PAIR_NUM(15)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .dir_mask_i   (dir_mask_i),
    .ctx_pairs_i  (ctx_pairs_i),
    .pair_o       (pair_o),
    .pair_valid_o (pair_valid_o),
    .pair_ready_i (pair_ready_i),
    .done_o       (done_o),
    .pair_cnt_o   (pair_cnt_o),
    .idle_o       (idle_o)
  );

  always #5 clk = ~clk;

  // Random pair set; empty_pct percent of entries get mode 00.
  function automatic logic [329:0] rand_pairs(input int empty_pct);
    logic [329:0] v;
    logic [10:0]  p;
    v = '0;
    for (int k = 0; k < 30; k++) begin
      p = 11'($urandom);
      if (int'($urandom_range(0, 99)) < empty_pct) p[10:9] = 2'b00;
      else if (p[10:9] == 2'b00) p[10:9] = 2'b01;
      v[k*11 +: 11] = p;
    end
    return v;
  endfunction

  // Runs one start from the current negedge. rmode: 0 ready high,
  // 1 ready alternating (low first), 2 random. intr: cycle index at which a
  // spurious start with garbage data is pulsed (-1 none). chain: leave the
  // bench sitting in the done cycle so the caller can start again there.
  task automatic run_case(input logic [1:0] dir, input logic [329:0] pairs,
                          input int rmode, input int intr, input bit chain,
                          input string tag);
    logic [10:0] q[$];
    logic [10:0] p;
    int n, acc, cyc;
    bit r;
    q = {};
    for (int k = 0; k < 30; k++) begin
      p = pairs[k*11 +: 11];
      if (p[10:9] != 2'b00 && dir[k/15]) q.push_back(p);
    end
    n = q.size();
    acc = 0;

    total++;
    if (idle_o !== 1'b1) $display("FAIL %s idle_before_start got=%b exp=1", tag, idle_o);
    else pass_cnt++;

    start_i = 1'b1; dir_mask_i = dir; ctx_pairs_i = pairs; pair_ready_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;

    for (cyc = 0; cyc < 300 && q.size() > 0; cyc++) begin
      total++;
      if (pair_valid_o !== 1'b1 || pair_o !== q[0]) begin
        $display("FAIL %s beat%0d got v=%b p=%h exp v=1 p=%h", tag, acc, pair_valid_o, pair_o, q[0]);
      end else pass_cnt++;
      total++;
      if (pair_cnt_o !== 5'(acc) || done_o !== 1'b0 || idle_o !== 1'b0) begin
        $display("FAIL %s busy_status cyc%0d got cnt=%0d done=%b idle=%b exp cnt=%0d done=0 idle=0",
                 tag, cyc, pair_cnt_o, done_o, idle_o, acc);
      end else pass_cnt++;

      case (rmode)
        0: r = 1'b1;
        1: r = (cyc % 2) == 1;
        default: r = 1'($urandom_range(0, 1));
      endcase
      pair_ready_i = r;
      if (cyc == intr) begin
        start_i = 1'b1;
        dir_mask_i = 2'b11;
        ctx_pairs_i = rand_pairs(0);
      end else begin
        start_i = 1'b0;
      end
      if (r) begin
        void'(q.pop_front());
        acc++;
      end
      @(negedge clk);
    end
    start_i = 1'b0;

    total++;
    if (q.size() != 0) $display("FAIL %s timeout remaining=%0d exp=0", tag, q.size());
    else pass_cnt++;

    total++;
    if (done_o !== 1'b1 || pair_valid_o !== 1'b0 || pair_cnt_o !== 5'(n) || idle_o !== 1'b1) begin
      $display("FAIL %s done_cycle got done=%b v=%b cnt=%0d idle=%b exp done=1 v=0 cnt=%0d idle=1",
               tag, done_o, pair_valid_o, pair_cnt_o, idle_o, n);
    end else pass_cnt++;

    if (!chain) begin
      pair_ready_i = 1'($urandom_range(0, 1));
      @(negedge clk);
      total++;
      if (done_o !== 1'b0 || pair_valid_o !== 1'b0 || pair_cnt_o !== 5'(n) || idle_o !== 1'b1) begin
        $display("FAIL %s after_done got done=%b v=%b cnt=%0d idle=%b exp done=0 v=0 cnt=%0d idle=1",
                 tag, done_o, pair_valid_o, pair_cnt_o, idle_o, n);
      end else pass_cnt++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (pair_o !== 11'h000 || pair_valid_o !== 1'b0 || done_o !== 1'b0 ||
        pair_cnt_o !== 5'd0 || idle_o !== 1'b1) begin
      $display("FAIL reset_state got p=%h v=%b done=%b cnt=%0d idle=%b exp 0 0 0 0 1",
               pair_o, pair_valid_o, done_o, pair_cnt_o, idle_o);
    end else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (pair_valid_o !== 1'b0 || done_o !== 1'b0 || idle_o !== 1'b1) begin
      $display("FAIL idle_after_reset got v=%b done=%b idle=%b exp 0 0 1", pair_valid_o, done_o, idle_o);
    end else pass_cnt++;
  endtask

  task automatic test_list0_basic();
    logic [329:0] v;
    v = '0;
    v[0*11 +: 11] = 11'h201;
    v[1*11 +: 11] = 11'h302;
    v[2*11 +: 11] = 11'h403;
    v[3*11 +: 11] = 11'h205;
    v[20*11 +: 11] = 11'h2AA;  // list1 entry, masked off by dir
    run_case(2'b01, v, 0, -1, 1'b0, "list0_basic");
  endtask

  function automatic logic [329:0] mixed_pairs();
    logic [329:0] v;
    v = '0;
    v[2*11 +: 11]  = 11'h210;
    v[15*11 +: 11] = 11'h420;
    v[29*11 +: 11] = 11'h630;
    return v;
  endfunction

  task automatic test_mixed();
    run_case(2'b11, mixed_pairs(), 0, -1, 1'b0, "mixed");
  endtask

  task automatic test_stall();
    run_case(2'b11, mixed_pairs(), 1, -1, 1'b0, "stall_alt");
  endtask

  task automatic test_empty();
    logic [329:0] v;
    v = rand_pairs(0);
    v[329:165] = '0;
    run_case(2'b10, v, 0, -1, 1'b0, "empty_dir");
    run_case(2'b11, '0, 0, -1, 1'b0, "empty_all");
  endtask

  task automatic test_back_to_back();
    run_case(2'b11, rand_pairs(0), 0, 3, 1'b1, "full_intrude");
    run_case(2'b11, mixed_pairs(), 0, -1, 1'b0, "start_in_done");
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      run_case(2'($urandom), rand_pairs(int'($urandom_range(0, 90))), 2,
               int'($urandom_range(0, 40)) - 10, 1'($urandom_range(0, 1)), "random");
    end
    pair_ready_i = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    start_i = 1'b1; dir_mask_i = 2'b11; ctx_pairs_i = rand_pairs(0); pair_ready_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (pair_valid_o !== 1'b1) $display("FAIL reset_mid_pre got v=%b exp=1", pair_valid_o);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total++;
    if (pair_valid_o !== 1'b0 || done_o !== 1'b0 || idle_o !== 1'b1 || pair_cnt_o !== 5'd0) begin
      $display("FAIL reset_mid got v=%b done=%b idle=%b cnt=%0d exp 0 0 1 0",
               pair_valid_o, done_o, idle_o, pair_cnt_o);
    end else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (done_o !== 1'b0 || pair_valid_o !== 1'b0 || idle_o !== 1'b1) begin
        $display("FAIL reset_mid_after cyc%0d got done=%b v=%b idle=%b exp 0 0 1",
                 i, done_o, pair_valid_o, idle_o);
      end else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_list0_basic();
    test_mixed();
    test_stall();
    test_empty();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
